// File: rtl/axi_wr_pkg.sv
// Shared constants and AW state encoding for the AXI4 write-burst master stage.
package axi_wr_pkg;

    localparam logic [2:0] AXSIZE_64B = 3'b110;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int         BEAT_BYTES = 64;

    typedef enum logic [1:0] {
        AW_IDLE,
        AW_SEND,
        AW_ACK
    } aw_state_t;

endpackage

// File: rtl/burst_len_fifo.sv
// Synchronous first-word-fall-through FIFO holding AW-accepted burst lengths until
// the W channel consumes them.
module burst_len_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB tells a full FIFO from an empty one when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// AXI4 write master stage: turns I/O-controller burst requests into AW transactions,
// beats the decompressed stream onto W with per-burst wlast, and reports B completions.
module axi_wr_burst_ctrl
    import axi_wr_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 512,
    parameter int LEN_FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  logic [7:0]          wr_len,
    input  logic [ADDR_W-1:0]   wr_address,
    output logic                wr_req_ack,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    input  logic                din_valid,
    input  logic [DATA_W-1:0]   din_data,
    output logic                din_ready,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    input  logic                bready_in,
    input  logic                m_axi_bvalid,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_bready,
    output logic                b_done,
    output logic                wr_err,
    output logic                busy
);

    localparam int OUT_W = $clog2(LEN_FIFO_DEPTH) + 2;

    if (DATA_W / 8 != BEAT_BYTES) begin : g_beat_width_check
        $error("DATA_W must carry exactly one 64-byte beat");
    end

    aw_state_t         state_q;
    aw_state_t         state_d;
    logic [ADDR_W-1:0] awaddr_q;
    logic [7:0]        awlen_q;
    logic              aw_hs;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;

    logic              w_active;
    logic [7:0]        cur_len;
    logic [7:0]        beat_cnt;
    logic              beat_hs;
    logic              last_hs;

    logic [OUT_W-1:0]  outstanding;

    // ---------------- AW channel ----------------
    assign aw_hs = (state_q == AW_SEND) && m_axi_awready;

    // NOTE: next-state defaults to the current state first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            AW_IDLE: if (wr_req && !fifo_full) state_d = AW_SEND;
            AW_SEND: if (m_axi_awready)        state_d = AW_ACK;
            AW_ACK:                            state_d = AW_IDLE;
            default:                           state_d = AW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= AW_IDLE;
            awaddr_q <= '0;
            awlen_q  <= '0;
        end else begin
            state_q <= state_d;
            // Request fields are only sampled on leaving IDLE; during ACK they are still stale.
            if (state_q == AW_IDLE && wr_req && !fifo_full) begin
                awaddr_q <= wr_address;
                awlen_q  <= wr_len;
            end
        end
    end

    assign m_axi_awvalid = (state_q == AW_SEND);
    assign wr_req_ack    = (state_q == AW_ACK);
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = AXSIZE_64B;
    assign m_axi_awburst = BURST_INCR;

    burst_len_fifo #(
        .DEPTH (LEN_FIFO_DEPTH),
        .WIDTH (8)
    ) u_len_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_hs),
        .din   (awlen_q),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- W channel ----------------
    assign beat_hs  = w_active && din_valid && m_axi_wready;
    assign last_hs  = beat_hs && (beat_cnt == cur_len);
    // Loading the next length on the last beat keeps back-to-back bursts bubble-free.
    assign fifo_pop = (!w_active || last_hs) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_active <= 1'b0;
            cur_len  <= '0;
            beat_cnt <= '0;
        end else if (fifo_pop) begin
            w_active <= 1'b1;
            cur_len  <= fifo_dout;
            beat_cnt <= '0;
        end else if (last_hs) begin
            w_active <= 1'b0;
        end else if (beat_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign m_axi_wvalid = w_active && din_valid;
    assign din_ready    = w_active && m_axi_wready;
    assign m_axi_wdata  = din_data;
    assign m_axi_wstrb  = '1;
    assign m_axi_wlast  = w_active && (beat_cnt == cur_len);

    // ---------------- B channel ----------------
    assign m_axi_bready = bready_in;
    assign b_done       = m_axi_bvalid && bready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            wr_err      <= 1'b0;
        end else begin
            unique case ({aw_hs, b_done})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (b_done && m_axi_bresp != 2'b00) begin
                wr_err <= 1'b1;
            end
        end
    end

    assign busy = (state_q != AW_IDLE) || !fifo_empty || w_active || (outstanding != '0);

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Directed self-checking bench for axi_wr_burst_ctrl with an I/O-controller request
// model, a counting data source and a W/AW monitor that checks wlast per expected burst.
module tb_axi_wr_burst_ctrl;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr_req = 1'b0;
    logic [7:0]          wr_len = '0;
    logic [ADDR_W-1:0]   wr_address = '0;
    logic                wr_req_ack;
    logic                m_axi_awvalid;
    logic                m_axi_awready = 1'b1;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                din_valid = 1'b1;
    logic [DATA_W-1:0]   din_data = '0;
    logic                din_ready;
    logic                m_axi_wvalid;
    logic                m_axi_wready = 1'b1;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic                bready_in = 1'b1;
    logic                m_axi_bvalid = 1'b0;
    logic [1:0]          m_axi_bresp = 2'b00;
    logic                m_axi_bready;
    logic                b_done;
    logic                wr_err;
    logic                busy;

    axi_wr_burst_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .LEN_FIFO_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req        (wr_req),
        .wr_len        (wr_len),
        .wr_address    (wr_address),
        .wr_req_ack    (wr_req_ack),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .din_valid     (din_valid),
        .din_data      (din_data),
        .din_ready     (din_ready),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .bready_in     (bready_in),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready),
        .b_done        (b_done),
        .wr_err        (wr_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        len;
        logic [ADDR_W-1:0] addr;
    } req_t;

    req_t              req_q[$];
    int                exp_len_q[$];
    logic [ADDR_W-1:0] aw_addr_q[$];
    logic [7:0]        aw_len_q[$];
    int                beat_cyc[$];
    logic [31:0]       src_cnt = '0;
    int                beat_total = 0;
    int                ack_cnt = 0;
    int                ack_long = 0;
    int                wlast_err = 0;
    int                data_err = 0;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int n = 0;
        while (beat_total < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(beat_total >= target), 64'd1);
    endtask

    task automatic wait_acks(input int target, input int budget, input string tag);
        int n = 0;
        while (ack_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(ack_cnt >= target), 64'd1);
    endtask

    task automatic b_send(input logic [1:0] resp, input string tag);
        tick();
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = resp;
        #1;
        check(tag, 64'(b_done), 64'd1);
        tick();
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        #1;
    endtask

    // I/O controller: holds wr_req and advances to the next request after each ack.
    initial begin : io_ctrl
        logic acked;
        forever begin
            @(negedge clk);
            acked = wr_req_ack;
            @(posedge clk);
            #1;
            if (acked && req_q.size() > 0) void'(req_q.pop_front());
            if (!rst_n || req_q.size() == 0) begin
                wr_req = 1'b0;
            end else begin
                wr_req     = 1'b1;
                wr_len     = req_q[0].len;
                wr_address = req_q[0].addr;
            end
        end
    end

    // Data source: a new counting pattern after each accepted beat.
    initial begin : data_src
        logic hs;
        forever begin
            @(negedge clk);
            hs = din_valid && din_ready;
            @(posedge clk);
            #1;
            if (hs) src_cnt = src_cnt + 1;
            din_data = {16{src_cnt}};
        end
    end

    // Monitor: logs AW handshakes, ack pulses and W beats; checks wlast against expected lengths.
    initial begin : monitor
        int cyc = 0;
        int pos = 0;
        logic ack_prev = 1'b0;
        logic exp_last;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pos      = 0;
                ack_prev = 1'b0;
            end else begin
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_addr_q.push_back(m_axi_awaddr);
                    aw_len_q.push_back(m_axi_awlen);
                end
                if (wr_req_ack) begin
                    ack_cnt++;
                    if (ack_prev) ack_long++;
                end
                ack_prev = wr_req_ack;
                if (m_axi_wvalid && m_axi_wready) begin
                    beat_total++;
                    beat_cyc.push_back(cyc);
                    if (m_axi_wdata !== {16{src_cnt}}) data_err++;
                    pos++;
                    if (exp_len_q.size() == 0) begin
                        wlast_err++;
                    end else begin
                        exp_last = (pos == exp_len_q[0] + 1);
                        if (m_axi_wlast !== exp_last) wlast_err++;
                        if (exp_last) begin
                            void'(exp_len_q.pop_front());
                            pos = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin : main
        int b0;
        int a0;
        int k0;
        int bad;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("rst_ack", 64'(wr_req_ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        check("rst_din_ready", 64'(din_ready), 64'd0);
        check("rst_awsize", 64'(m_axi_awsize), 64'h6);
        check("rst_awburst", 64'(m_axi_awburst), 64'h1);
        check("rst_wstrb_ones", 64'(&m_axi_wstrb), 64'd1);
        rst_n = 1'b1;
        tick();

        // ---- single 64-beat burst ----
        b0 = beat_total; a0 = aw_addr_q.size(); k0 = ack_cnt;
        exp_len_q.push_back(63);
        req_q.push_back('{8'h3F, 64'h1000});
        wait_beats(b0 + 64, 300, "t1_beats_done");
        tick();
        check("t1_aw_count", 64'(aw_addr_q.size() - a0), 64'd1);
        check("t1_awaddr", aw_addr_q[a0], 64'h1000);
        check("t1_awlen", 64'(aw_len_q[a0]), 64'h3F);
        check("t1_ack_count", 64'(ack_cnt - k0), 64'd1);
        check("t1_beat_count", 64'(beat_total - b0), 64'd64);
        check("t1_busy_b_pending", 64'(busy), 64'd1);
        b_send(2'b00, "t1_b_done");
        check("t1_b_done_idle", 64'(b_done), 64'd0);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // ---- back-to-back bursts held on one wr_req ----
        b0 = beat_total; a0 = aw_addr_q.size();
        exp_len_q.push_back(63); exp_len_q.push_back(63); exp_len_q.push_back(4);
        req_q.push_back('{8'h3F, 64'h0000});
        req_q.push_back('{8'h3F, 64'h1000});
        req_q.push_back('{8'h04, 64'h2000});
        wait_beats(b0 + 133, 500, "t2_beats_done");
        tick();
        check("t2_aw_count", 64'(aw_addr_q.size() - a0), 64'd3);
        check("t2_awaddr0", aw_addr_q[a0], 64'h0000);
        check("t2_awaddr1", aw_addr_q[a0+1], 64'h1000);
        check("t2_awaddr2", aw_addr_q[a0+2], 64'h2000);
        check("t2_awlen1", 64'(aw_len_q[a0+1]), 64'h3F);
        check("t2_awlen2", 64'(aw_len_q[a0+2]), 64'h04);
        check("t2_no_bubble", 64'(beat_cyc[b0+132] - beat_cyc[b0]), 64'd132);

        // ---- B responses, error on the second ----
        b_send(2'b00, "b1_done");
        check("b1_wr_err", 64'(wr_err), 64'd0);
        b_send(2'b10, "b2_done");
        check("b2_wr_err", 64'(wr_err), 64'd1);
        check("b2_busy", 64'(busy), 64'd1);
        b_send(2'b00, "b3_done");
        check("b3_wr_err_sticky", 64'(wr_err), 64'd1);
        check("b3_busy_drop", 64'(busy), 64'd0);

        // ---- AW backpressure on a single-beat burst ----
        tick();
        m_axi_awready = 1'b0;
        b0 = beat_total; a0 = aw_addr_q.size(); k0 = ack_cnt;
        exp_len_q.push_back(0);
        req_q.push_back('{8'h00, 64'h3000});
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 64'h3000 || m_axi_awlen !== 8'h00) bad++;
            @(negedge clk);
        end
        check("t3_aw_stable", 64'(bad), 64'd0);
        check("t3_no_early_ack", 64'(ack_cnt - k0), 64'd0);
        tick();
        m_axi_awready = 1'b1;
        wait_acks(k0 + 1, 10, "t3_ack_seen");
        wait_beats(b0 + 1, 20, "t3_single_beat");
        tick();
        check("t3_aw_count", 64'(aw_addr_q.size() - a0), 64'd1);
        b_send(2'b00, "t3_b_done");
        check("t3_busy_idle", 64'(busy), 64'd0);

        // ---- FIFO full: one burst sits in the W stage, eight wait in the FIFO ----
        tick();
        m_axi_wready = 1'b0;
        b0 = beat_total; a0 = aw_addr_q.size(); k0 = ack_cnt;
        for (int i = 0; i < 10; i++) begin
            exp_len_q.push_back(3);
            req_q.push_back('{8'h03, 64'h10000 + 64'(i) * 64'h1000});
        end
        repeat (60) @(negedge clk);
        check("t4_aw_when_full", 64'(aw_addr_q.size() - a0), 64'd9);
        check("t4_ack_when_full", 64'(ack_cnt - k0), 64'd9);
        check("t4_no_beats", 64'(beat_total - b0), 64'd0);
        check("t4_wlast_low", 64'(m_axi_wlast), 64'd0);
        tick();
        m_axi_wready = 1'b1;
        wait_beats(b0 + 40, 400, "t4_drain");
        tick();
        check("t4_tenth_aw", 64'(aw_addr_q.size() - a0), 64'd10);
        check("t4_tenth_addr", aw_addr_q[a0+9], 64'h19000);
        for (int i = 0; i < 10; i++) b_send(2'b00, "t4_b_done");
        check("t4_busy_idle", 64'(busy), 64'd0);

        // ---- async reset mid-burst ----
        tick();
        b0 = beat_total;
        exp_len_q.push_back(63);
        req_q.push_back('{8'h3F, 64'h5000});
        wait_beats(b0 + 20, 100, "t5_beat20");
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("t5_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("t5_din_ready", 64'(din_ready), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_wr_err_cleared", 64'(wr_err), 64'd0);
        req_q.delete();
        exp_len_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        b0 = beat_total; a0 = aw_addr_q.size();
        exp_len_q.push_back(1);
        req_q.push_back('{8'h01, 64'h6000});
        wait_beats(b0 + 2, 100, "t5_restart_beats");
        tick();
        check("t5_restart_aw_count", 64'(aw_addr_q.size() - a0), 64'd1);
        check("t5_restart_addr", aw_addr_q[a0], 64'h6000);
        check("t5_restart_len", 64'(aw_len_q[a0]), 64'h01);
        check("t5_restart_beats_exact", 64'(beat_total - b0), 64'd2);
        b_send(2'b00, "t5_b_done");
        check("t5_busy_idle", 64'(busy), 64'd0);
        check("t5_wr_err_clean", 64'(wr_err), 64'd0);

        // ---- whole-run monitor results ----
        check("wlast_placement", 64'(wlast_err), 64'd0);
        check("wdata_passthrough", 64'(data_err), 64'd0);
        check("ack_single_cycle", 64'(ack_long), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
